// File: rtl/trng_vn_harvester.sv
// Entropy harvester: synchronised XOR of NUM_SRC cells, von Neumann debias, word packing.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_TEST_EN.
module trng_vn_harvester #(
  parameter int NUM_SRC    = 4,
  parameter int OUT_WIDTH  = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int REP_LIMIT  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_SRC-1:0]   src_in,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 health_fail
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = $clog2(OUT_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_WIDTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_HAVE1 = 1'b1;

  if (NUM_SRC < 1 || OUT_WIDTH < 2 || SAMPLE_DIV < 1 || REP_LIMIT < 2) begin : g_bad_param
    $error("trng_vn_harvester: parameter out of range");
  end

  logic [NUM_SRC-1:0]   r_sync1;
  logic [NUM_SRC-1:0]   r_sync2;
  logic [DIV_W-1:0]     r_div;
  logic [0:0]           r_state;
  logic                 r_b0;
  logic [OUT_WIDTH-2:0] r_sr;
  logic [CNT_W-1:0]     r_cnt;
  logic [OUT_WIDTH-1:0] r_data;
  logic                 r_valid;

  logic                 w_raw;
  logic                 w_strobe;
  logic                 w_inhibit;
  logic                 w_emit;
  logic                 w_last;
  logic                 w_xfer;
  logic [OUT_WIDTH-1:0] w_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= src_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw    = ^r_sync2;
  assign w_strobe = ena & (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (ena) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    end
  end

  // A bit is produced only on the second sample of a pair, and only when the two differ.
  assign w_emit = w_strobe & ~w_inhibit & (r_state == S_HAVE1) & (w_raw != r_b0);
  assign w_word = {r_sr, r_b0};
  assign w_last = w_emit & (r_cnt == CNT_LAST);
  assign w_xfer = r_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_b0    <= 1'b0;
    end else if (w_inhibit) begin
      r_state <= S_IDLE;
    end else if (w_strobe) begin
      case (r_state)
        S_IDLE: begin
          r_b0    <= w_raw;
          r_state <= S_HAVE1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_emit) begin
      r_sr  <= w_word[OUT_WIDTH-2:0];
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // A completed word that finds the output slot still occupied is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_last && (!r_valid || w_xfer)) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;

`ifdef TRNG_HEALTH_TEST_EN
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

  logic [REP_W-1:0] r_rep;
  logic             r_prev_raw;
  logic             r_health;
  logic [REP_W-1:0] w_rep_next;

  always_comb begin
    w_rep_next = r_rep;
    if (w_raw != r_prev_raw) begin
      w_rep_next = REP_W'(1);
    end else if (r_rep != REP_MAX) begin
      w_rep_next = r_rep + REP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep      <= '0;
      r_prev_raw <= 1'b0;
      r_health   <= 1'b0;
    end else if (w_strobe) begin
      r_rep      <= w_rep_next;
      r_prev_raw <= w_raw;
      if (w_rep_next == REP_MAX) r_health <= 1'b1;
    end
  end

  assign w_inhibit   = r_health;
  assign health_fail = r_health;
`else
  assign w_inhibit   = 1'b0;
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_trng_vn_harvester.sv
// Randomised bench for trng_vn_harvester against a sample/pair/word queue model.
module tb_trng_vn_harvester;
  localparam int NS  = 3;
  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int LIM = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [NS-1:0] src_in = '0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          health_fail;

  trng_vn_harvester #(
    .NUM_SRC(NS), .OUT_WIDTH(W), .SAMPLE_DIV(DIV), .REP_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .src_in(src_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: raw sample = parity of src driven two edges earlier.
  logic [NS-1:0] src_hist[$];
  int            en_cnt;
  bit            raw_q[$];
  bit            bits_q[$];
  logic [W-1:0]  m_data;
  bit            m_valid;
  bit            m_health;
  bit            m_last_raw;
  int            m_run;

  function automatic void model_reset();
    src_hist.delete();
    raw_q.delete();
    bits_q.delete();
    en_cnt     = 0;
    m_data     = '0;
    m_valid    = 1'b0;
    m_health   = 1'b0;
    m_last_raw = 1'b0;
    m_run      = 0;
  endfunction

  function automatic void model_edge();
    bit           raw;
    bit           strobe;
    bit           xfer;
    bit           h_prev;
    logic [W-1:0] word;
    src_hist.push_back(src_in);
    if (src_hist.size() > 3) void'(src_hist.pop_front());
    raw    = (src_hist.size() == 3) ? ^src_hist[0] : 1'b0;
    xfer   = m_valid && out_ready;
    h_prev = m_health;
    strobe = 1'b0;
    if (ena) begin
      en_cnt++;
      strobe = (en_cnt % DIV) == 0;
    end
    if (xfer) $display("xfer data=%02h", m_data);
    if (strobe) begin
`ifdef TRNG_HEALTH_TEST_EN
      m_run      = (raw == m_last_raw) ? ((m_run < LIM) ? m_run + 1 : LIM) : 1;
      m_last_raw = raw;
      if (m_run >= LIM) m_health = 1'b1;
`endif
      if (h_prev) begin
        raw_q.delete();
      end else begin
        raw_q.push_back(raw);
        if (raw_q.size() == 2) begin
          if (raw_q[0] != raw_q[1]) bits_q.push_back(raw_q[0]);
          raw_q.delete();
        end
      end
    end
    if (bits_q.size() == W) begin
      for (int i = 0; i < W; i++) word[W-1-i] = bits_q[i];
      bits_q.delete();
      if (!m_valid || xfer) begin
        m_data  = word;
        m_valid = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_data", 32'(out_data), 32'(m_data));
    check_eq("health_fail", 32'(health_fail), 32'(m_health));
  endtask

  // Drive a random source vector whose parity is r, held for n clocks.
  task automatic run_level(input bit r, input int n);
    logic [NS-1:0] s;
    for (int i = 0; i < n; i++) begin
      s = NS'($urandom);
      if ((^s) != r) s[0] = ~s[0];
      src_in = s;
      step();
    end
  endtask

  task automatic run_random(input int n, input bit rand_ready);
    int seg;
    for (int i = 0; i < n; i += seg) begin
      seg = DIV * int'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 0) begin
        for (int j = 0; j < seg; j++) begin
          src_in    = NS'($urandom);
          ena       = ($urandom_range(0, 7) != 0);
          out_ready = rand_ready ? 1'($urandom) : 1'b0;
          step();
        end
      end else begin
        ena       = 1'b1;
        out_ready = rand_ready ? 1'($urandom) : 1'b0;
        run_level(1'($urandom), seg);
      end
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) step();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    ena   = 1'b1;

    // Pairs 10,01 repeated: word 8'hAA
    for (int k = 0; k < 4; k++) begin
      run_level(1'b1, DIV); run_level(1'b0, DIV);
      run_level(1'b0, DIV); run_level(1'b1, DIV);
    end
    check_eq("aa_valid", 32'(out_valid), 32'd1);
    check_eq("aa_data", 32'(out_data), 32'hAA);

    // Second word 8'h55 under backpressure must be dropped
    for (int k = 0; k < 4; k++) begin
      run_level(1'b0, DIV); run_level(1'b1, DIV);
      run_level(1'b1, DIV); run_level(1'b0, DIV);
    end
    check_eq("bp_data", 32'(out_data), 32'hAA);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("bp_xfer_valid", 32'(out_valid), 32'd0);

    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      src_in = NS'($urandom);
      step();
    end
    ena = 1'b1;

    run_random(2000, 1'b1);
    run_random(300, 1'b0);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_valid", 32'(out_valid), 32'd0);
    check_eq("async_data", 32'(out_data), 32'd0);
    check_eq("async_health", 32'(health_fail), 32'd0);
    step();
    rst_n     = 1'b1;
    ena       = 1'b1;
    out_ready = 1'b0;

    // Fresh word after reset needs the full 16 strobes: (1,0) x8 -> 8'hFF
    for (int k = 0; k < 7; k++) begin
      run_level(1'b1, DIV); run_level(1'b0, DIV);
    end
    run_level(1'b1, DIV);
    run_level(1'b0, DIV - 1);
    check_eq("fresh_not_yet", 32'(out_valid), 32'd0);
    run_level(1'b0, 1);
    check_eq("fresh_valid", 32'(out_valid), 32'd1);
    check_eq("fresh_data", 32'(out_data), 32'hFF);

    run_random(1500, 1'b1);

    // Constant raw 0 for many strobes
    ena       = 1'b1;
    out_ready = 1'b1;
    run_level(1'b0, DIV * 100);
`ifdef TRNG_HEALTH_TEST_EN
    check_eq("health_const", 32'(health_fail), 32'd1);
`else
    check_eq("health_const", 32'(health_fail), 32'd0);
`endif
    check_eq("const_no_word", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
